// File: rtl/adc_buf_pkg.sv
// Shared constants, read-FSM state encoding and index-width helper for the
// ADC capture front end.
package adc_buf_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FRAME_LEN  = 16;
  localparam int DEF_SAMPLE_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } rd_state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ADC sample clock generator: free-running divider, registered adclk and a
// sample strobe on the last count of each period.
module adc_clk_div
  import adc_buf_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_adclk,
  output logic o_strobe
);

  localparam int DIV_W = clog2(SAMPLE_DIV);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_adclk;

  assign w_div_next = (r_div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : r_div + DIV_W'(1);

  // adclk is registered from the next count so it stays aligned with div
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div   <= '0;
      r_adclk <= 1'b0;
    end else begin
      r_div   <= w_div_next;
      r_adclk <= (w_div_next < DIV_W'(SAMPLE_DIV / 2));
    end
  end

  assign o_adclk  = r_adclk;
  assign o_strobe = (r_div == DIV_W'(SAMPLE_DIV - 1));

endmodule

// File: rtl/adc_frame_buffer.sv
// Ping-pong ADC frame capture with pair streaming to the FFT controller.
// Define ADC_OFFSET_BIN_EN to invert the sample MSB (offset-binary -> two's complement).
module adc_frame_buffer
  import adc_buf_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic              global_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adin_data,
  input  logic              fft_ready,
  output logic              adclk,
  output logic              start,
  output logic              pair_valid,
  output logic [DATA_W-1:0] sampled_in_0,
  output logic [DATA_W-1:0] sampled_in_1,
  output logic [7:0]        frame_drop_cnt
);

  localparam int IDX_W = clog2(FRAME_LEN);

  logic              w_strobe;
  logic [DATA_W-1:0] w_sample;
  logic [IDX_W-1:0]  r_widx;
  logic              r_wbank;
  logic [1:0]        r_full;
  logic [7:0]        r_drop_cnt;
  logic              w_rbank;
  logic              w_wr_en;
  logic              w_frame_done;
  logic              w_release;
  logic [IDX_W-1:0]  w_wr_addr;
  logic [IDX_W-1:0]  w_rd_addr;
  logic [1:0]        w_full_next;
  logic              w_wbank_next;
  logic [7:0]        w_drop_next;

  rd_state_t         r_state;
  rd_state_t         w_state_next;
  logic [IDX_W-1:0]  r_ridx;
  logic [IDX_W-1:0]  w_ridx_next;
  logic              w_load;
  logic [IDX_W-2:0]  w_rd_pair;
  logic              r_start;
  logic              r_valid;

  adc_clk_div #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_clk_div (
    .i_clk   (global_clk),
    .i_rst   (rst),
    .o_adclk (adclk),
    .o_strobe(w_strobe)
  );

`ifdef ADC_OFFSET_BIN_EN
  assign w_sample = {~adin_data[DATA_W-1], adin_data[DATA_W-2:0]};
`else
  assign w_sample = adin_data;
`endif

  assign w_rbank      = ~r_wbank;
  assign w_wr_en      = w_strobe & ~rst;
  assign w_frame_done = w_strobe && (r_widx == IDX_W'(FRAME_LEN - 1));
  assign w_release    = (r_state == ST_DONE);
  assign w_wr_addr    = {r_wbank, r_widx[IDX_W-1:1]};
  assign w_rd_addr    = {w_rbank, w_rd_pair};

  // A release in the same cycle frees the read bank before the drop decision
  always_comb begin
    w_full_next  = r_full;
    w_wbank_next = r_wbank;
    w_drop_next  = r_drop_cnt;
    if (w_release) begin
      w_full_next[w_rbank] = 1'b0;
    end
    if (w_frame_done) begin
      if (!w_full_next[w_rbank]) begin
        w_full_next[r_wbank] = 1'b1;
        w_wbank_next         = ~r_wbank;
      end else begin
        w_full_next[r_wbank] = 1'b0;
        if (r_drop_cnt != 8'hFF) begin
          w_drop_next = r_drop_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge global_clk) begin
    if (rst) begin
      r_widx     <= '0;
      r_wbank    <= 1'b0;
      r_full     <= 2'b00;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_strobe) begin
        r_widx <= r_widx + IDX_W'(1);
      end
      r_wbank    <= w_wbank_next;
      r_full     <= w_full_next;
      r_drop_cnt <= w_drop_next;
    end
  end

  always_ff @(posedge global_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (r_full[w_rbank] && fft_ready) w_state_next = ST_START;
      ST_START:  w_state_next = ST_STREAM;
      ST_STREAM: if (r_ridx == '0) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // The RAM read is registered, so the pair for the next cycle is addressed now;
  // in STREAM a wrapped ridx means every pair has already been fetched.
  always_comb begin
    w_load      = 1'b0;
    w_rd_pair   = '0;
    w_ridx_next = r_ridx;
    case (r_state)
      ST_START: begin
        w_load      = 1'b1;
        w_rd_pair   = '0;
        w_ridx_next = IDX_W'(2);
      end
      ST_STREAM: begin
        if (r_ridx != '0) begin
          w_load      = 1'b1;
          w_rd_pair   = r_ridx[IDX_W-1:1];
          w_ridx_next = r_ridx + IDX_W'(2);
        end
      end
      default: begin
        w_load      = 1'b0;
        w_ridx_next = r_ridx;
      end
    endcase
  end

  always_ff @(posedge global_clk) begin
    if (rst) begin
      r_ridx  <= '0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_ridx  <= w_ridx_next;
      r_start <= (w_state_next == ST_START);
      r_valid <= w_load;
    end
  end

  // Lane 0 holds even-index samples, lane 1 odd; each is one write, one read port
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DATA_W-1:0] r_mem [FRAME_LEN];
    logic [DATA_W-1:0] r_rd;

    always_ff @(posedge global_clk) begin
      if (w_wr_en && (r_widx[0] == 1'(gi))) begin
        r_mem[w_wr_addr] <= w_sample;
      end
    end

    always_ff @(posedge global_clk) begin
      if (rst) begin
        r_rd <= '0;
      end else if (w_load) begin
        r_rd <= r_mem[w_rd_addr];
      end
    end
  end

  assign start          = r_start;
  assign pair_valid     = r_valid;
  assign sampled_in_0   = g_lane[0].r_rd;
  assign sampled_in_1   = g_lane[1].r_rd;
  assign frame_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Randomized bench for adc_frame_buffer against a frame-level occupancy model.
// Honors ADC_OFFSET_BIN_EN the same way as the design.
module tb_adc_frame_buffer;

  logic       global_clk = 1'b0;
  logic       rst;
  logic [7:0] adin_data;
  logic       fft_ready;
  logic       adclk;
  logic       start;
  logic       pair_valid;
  logic [7:0] sampled_in_0;
  logic [7:0] sampled_in_1;
  logic [7:0] frame_drop_cnt;

  always #5 global_clk = ~global_clk;

  adc_frame_buffer dut (
    .global_clk    (global_clk),
    .rst           (rst),
    .adin_data     (adin_data),
    .fft_ready     (fft_ready),
    .adclk         (adclk),
    .start         (start),
    .pair_valid    (pair_valid),
    .sampled_in_0  (sampled_in_0),
    .sampled_in_1  (sampled_in_1),
    .frame_drop_cnt(frame_drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frames are arrays; the reader is a 10-cycle occupancy
  // window (1 start, 8 pairs, 1 release cycle) over the pending frame.
  int         m_div, m_widx, m_t, m_drops;
  bit         m_pend_v;
  logic [7:0] m_cur  [16];
  logic [7:0] m_pend [16];
  bit         e_start, e_valid, e_adclk;
  logic [7:0] e_s0, e_s1;

  int mode;      // 0 random, 1 ramp, 2 constant 0x80
  int ramp_v;
  int n_start, n_pairs;
  bit prev_start;
  logic [7:0] first_q[$];

  function automatic logic [7:0] cond(input logic [7:0] x);
`ifdef ADC_OFFSET_BIN_EN
    return x ^ 8'h80;
`else
    return x;
`endif
  endfunction

  task automatic model_step();
    bit rel, strobe, done;
    if (rst) begin
      m_div = 0; m_widx = 0; m_t = 0; m_pend_v = 0; m_drops = 0;
      e_start = 0; e_valid = 0; e_adclk = 0; e_s0 = 8'h00; e_s1 = 8'h00;
    end else begin
      rel    = (m_t == 10);
      strobe = (m_div == 3);
      done   = 0;
      if (strobe) begin
        m_cur[m_widx] = cond(adin_data);
        m_widx++;
        if (mode == 1) ramp_v++;
        if (m_widx == 16) begin
          m_widx = 0;
          done   = 1;
        end
      end
      if (m_t == 10) m_t = 0;
      else if (m_t > 0) m_t++;
      else if (m_pend_v && fft_ready) m_t = 1;
      if (rel) m_pend_v = 0;
      if (done) begin
        if (m_pend_v) begin
          if (m_drops < 255) m_drops++;
        end else begin
          m_pend_v = 1;
          m_pend   = m_cur;
        end
      end
      m_div   = (m_div + 1) % 4;
      e_adclk = (m_div < 2);
      e_start = (m_t == 1);
      e_valid = (m_t >= 2 && m_t <= 9);
      if (e_valid) begin
        e_s0 = m_pend[2 * (m_t - 2)];
        e_s1 = m_pend[2 * (m_t - 2) + 1];
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("start", start, e_start);
    check_eq("pair_valid", pair_valid, e_valid);
    check_eq("sampled_in_0", sampled_in_0, e_s0);
    check_eq("sampled_in_1", sampled_in_1, e_s1);
    check_eq("adclk", adclk, e_adclk);
    check_eq("frame_drop_cnt", frame_drop_cnt, m_drops);
    if (start) n_start++;
    if (pair_valid) n_pairs++;
    if (pair_valid && prev_start) first_q.push_back(sampled_in_0);
    prev_start = start;
  endtask

  task automatic drive_data();
    case (mode)
      0:       adin_data = 8'($urandom);
      1:       adin_data = ramp_v[7:0];
      default: adin_data = 8'h80;
    endcase
  endtask

  task automatic tick();
    @(posedge global_clk);
    model_step();
    @(negedge global_clk);
    compare_outputs();
    drive_data();
  endtask

  task automatic do_reset(input int new_mode, input bit ready);
    rst = 1'b1;
    tick();
    tick();
    rst       = 1'b0;
    mode      = new_mode;
    ramp_v    = 0;
    fft_ready = ready;
    n_start   = 0;
    n_pairs   = 0;
    first_q.delete();
    drive_data();
  endtask

  task automatic wait_ramp(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && ramp_v < target; i++) tick();
    check_eq(tag, (ramp_v >= target), 1);
  endtask

  initial begin
    int steps;
    rst = 1'b1; fft_ready = 1'b0; adin_data = 8'h00; mode = 1; ramp_v = 0;
    prev_start = 0;

    // Ramp frame with FFT always ready
    do_reset(1, 1'b1);
    wait_ramp(16, 200, "ramp_wait");
    repeat (12) tick();
    check_eq("ramp_starts", n_start, 1);
    check_eq("ramp_pairs", n_pairs, 8);
    check_eq("ramp_first", (first_q.size() > 0) ? first_q[0] : 8'hEE, cond(8'h00));
    check_eq("ramp_drops", frame_drop_cnt, 0);

    // FFT held off across three frames: one drop, frames 0 and 2 stream
    do_reset(1, 1'b0);
    wait_ramp(40, 400, "hold_wait");
    fft_ready = 1'b1;
    wait_ramp(48, 200, "hold_wait2");
    repeat (14) tick();
    check_eq("hold_drops", frame_drop_cnt, 1);
    check_eq("hold_frames", first_q.size(), 2);
    if (first_q.size() >= 2) begin
      check_eq("hold_frame0", first_q[0], cond(8'd0));
      check_eq("hold_frame2", first_q[1], cond(8'd32));
    end

    // Reset while the fourth pair is on the outputs
    do_reset(0, 1'b1);
    for (int i = 0; i < 200 && m_t != 5; i++) tick();
    check_eq("midstream_wait", m_t, 5);
    rst = 1'b1;
    tick();
    check_eq("rst_pair_valid", pair_valid, 0);
    check_eq("rst_start", start, 0);
    check_eq("rst_drops", frame_drop_cnt, 0);
    rst = 1'b0;
    n_start = 0;
    n_pairs = 0;
    repeat (90) tick();
    check_eq("post_rst_starts", n_start, 1);
    check_eq("post_rst_pairs", n_pairs, 8);

    // Release lands on the same edge as the next frame completion
    do_reset(0, 1'b0);
    for (int i = 0; i < 200 && !m_pend_v; i++) tick();
    check_eq("coinc_pending", m_pend_v, 1);
    steps = 0;
    while (steps < 100 && ((15 - m_widx) * 4 + (3 - m_div) + 1) != 11) begin
      tick();
      steps++;
    end
    check_eq("coinc_align", (15 - m_widx) * 4 + (3 - m_div) + 1, 11);
    fft_ready = 1'b1;
    n_start = 0;
    repeat (25) tick();
    check_eq("coinc_drops", frame_drop_cnt, 0);
    check_eq("coinc_starts", n_start, 2);

    // Constant mid-scale input
    do_reset(2, 1'b1);
    repeat (90) tick();
    check_eq("const_pairs", n_pairs, 8);
    check_eq("const_first", (first_q.size() > 0) ? first_q[0] : 8'hEE,
`ifdef ADC_OFFSET_BIN_EN
             8'h00
`else
             8'h80
`endif
    );

    // Random data with randomly toggling fft_ready
    do_reset(0, 1'b1);
    for (int i = 0; i < 2500; i++) begin
      tick();
      if ($urandom_range(0, 47) == 0) fft_ready = ~fft_ready;
    end
    check_eq("rand_drops", frame_drop_cnt, m_drops);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
